// File: rtl/caxi4dma_ctrl_if_mux_reg.sv
// caxi4dma_ctrl_if_mux_reg
// Registered control-interface address mux for the DMA controller.
// One register access at a time is decoded against NUM_TGT address windows
// and forwarded to exactly one register block through a one-hot select. The
// block's ready completes the access, and the read data and error flag are
// returned through registers. Unmapped addresses complete with an error.
//
// Optional feature: define CAXI4DMA_CTRL_IF_TIMEOUT_EN to build a watchdog
// that errors out an access whose target stays silent for TIMEOUT_CYC
// cycles. Without it, ACCESS waits for the target indefinitely.
module caxi4dma_ctrl_if_mux_reg #(
    parameter int unsigned                NUM_TGT     = 4,
    parameter int unsigned                ADDR_W      = 11,
    parameter int unsigned                DATA_W      = 32,
    parameter logic [NUM_TGT*ADDR_W-1:0]  TGT_BASE    = {11'h460, 11'h060, 11'h004, 11'h000},
    parameter logic [NUM_TGT*ADDR_W-1:0]  TGT_LIMIT   = {11'h7FF, 11'h45F, 11'h05F, 11'h003},
    parameter int unsigned                TIMEOUT_CYC = 256,
    parameter logic [DATA_W-1:0]          ERR_RDATA   = DATA_W'(32'hDEADBEEF)
) (
    input  logic                        clock,
    input  logic                        resetn,
    // control slave side
    input  logic                        ctrl_sel,
    input  logic                        ctrl_wen,
    input  logic [ADDR_W-1:0]           ctrl_addr,
    input  logic [DATA_W-1:0]           ctrl_wdata,
    input  logic [DATA_W/8-1:0]         ctrl_wstrb,
    output logic                        ctrl_ready,
    output logic [DATA_W-1:0]           ctrl_rdata,
    output logic                        ctrl_err,
    // register block side
    output logic [NUM_TGT-1:0]          tgt_sel,
    output logic                        tgt_wen,
    output logic [ADDR_W-1:0]           tgt_addr,
    output logic [DATA_W-1:0]           tgt_wdata,
    output logic [DATA_W/8-1:0]         tgt_wstrb,
    input  logic [NUM_TGT*DATA_W-1:0]   tgt_rdata,
    input  logic [NUM_TGT-1:0]          tgt_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic [NUM_TGT-1:0]  hit_vec;
    logic                hit_any;
    logic [DATA_W-1:0]   sel_rdata;
    logic                sel_ready;
    logic                tmo_expired;

    // Captured completion, presented on the ctrl_* outputs for one cycle.
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;

    // Window decode of the incoming address; lowest index wins on overlap.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // otherwise synthesis infers a latch to hold the old value.
        hit_vec = '0;
        hit_any = 1'b0;
        for (int i = int'(NUM_TGT) - 1; i >= 0; i--) begin
            if ((ctrl_addr >= TGT_BASE[i*ADDR_W +: ADDR_W]) &&
                (ctrl_addr <= TGT_LIMIT[i*ADDR_W +: ADDR_W])) begin
                hit_vec    = '0;
                hit_vec[i] = 1'b1;
                hit_any    = 1'b1;
            end
        end
    end

    // Ready and read data of the selected target only; tgt_sel is one-hot or zero.
    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        for (int i = 0; i < int'(NUM_TGT); i++) begin
            if (tgt_sel[i]) begin
                sel_rdata = sel_rdata | tgt_rdata[i*DATA_W +: DATA_W];
                sel_ready = sel_ready | tgt_ready[i];
            end
        end
    end

`ifdef CAXI4DMA_CTRL_IF_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] tmo_cnt;

    // Counts ACCESS cycles; held at zero outside ACCESS so it starts fresh on entry.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt <= '0;
        end else if (state_q == ACCESS) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    // The last permitted ACCESS cycle is the one with the count at TIMEOUT_CYC-1.
    assign tmo_expired = (state_q == ACCESS) && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign tmo_expired = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples its pre-edge inputs regardless of statement order.
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; target ready takes priority over timeout expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ctrl_sel) begin
                    state_d = hit_any ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (sel_ready || tmo_expired) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request capture, target select and completion capture.
    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: the response registers are reset too, even though ctrl_* is
        // gated by RESP, so no X can ever reach the bus after reset.
        if (!resetn) begin
            tgt_sel     <= '0;
            tgt_wen     <= 1'b0;
            tgt_addr    <= '0;
            tgt_wdata   <= '0;
            tgt_wstrb   <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ctrl_sel) begin
                        tgt_wen   <= ctrl_wen;
                        tgt_addr  <= ctrl_addr;
                        tgt_wdata <= ctrl_wdata;
                        tgt_wstrb <= ctrl_wstrb;
                        // A miss leaves tgt_sel at zero, so no target sees it.
                        tgt_sel   <= hit_vec;
                        if (!hit_any) begin
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= ctrl_wen ? '0 : ERR_RDATA;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ready) begin
                        tgt_sel     <= '0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= tgt_wen ? '0 : sel_rdata;
                    end else if (tmo_expired) begin
                        tgt_sel     <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= tgt_wen ? '0 : ERR_RDATA;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // One-cycle completion pulse; data and error are zero outside the pulse.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ctrl_ready <= 1'b0;
            ctrl_rdata <= '0;
            ctrl_err   <= 1'b0;
        end else begin
            ctrl_ready <= (state_q == RESP);
            ctrl_rdata <= (state_q == RESP) ? rsp_rdata_q : '0;
            ctrl_err   <= (state_q == RESP) ? rsp_err_q : 1'b0;
        end
    end

endmodule

// File: tb/tb_caxi4dma_ctrl_if_mux_reg.sv
// Directed bench for caxi4dma_ctrl_if_mux_reg. Target 3's window is narrowed
// to 0x460..0x5FF so addresses above 0x5FF are unmapped. The timeout section
// runs only when CAXI4DMA_CTRL_IF_TIMEOUT_EN is defined.
module tb_caxi4dma_ctrl_if_mux_reg;

    localparam int NT = 4;
    localparam int AW = 11;
    localparam int DW = 32;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              ctrl_sel = 1'b0;
    logic              ctrl_wen = 1'b0;
    logic [AW-1:0]     ctrl_addr = '0;
    logic [DW-1:0]     ctrl_wdata = '0;
    logic [DW/8-1:0]   ctrl_wstrb = '0;
    logic              ctrl_ready;
    logic [DW-1:0]     ctrl_rdata;
    logic              ctrl_err;
    logic [NT-1:0]     tgt_sel;
    logic              tgt_wen;
    logic [AW-1:0]     tgt_addr;
    logic [DW-1:0]     tgt_wdata;
    logic [DW/8-1:0]   tgt_wstrb;
    logic [NT*DW-1:0]  tgt_rdata = '0;
    logic [NT-1:0]     tgt_ready = '0;

    int checks = 0;
    int failures = 0;
    int n_high;

    caxi4dma_ctrl_if_mux_reg #(
        .NUM_TGT     (NT),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TGT_BASE    ({11'h460, 11'h060, 11'h004, 11'h000}),
        .TGT_LIMIT   ({11'h5FF, 11'h45F, 11'h05F, 11'h003}),
        .TIMEOUT_CYC (8),
        .ERR_RDATA   (32'hDEADBEEF)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .ctrl_sel   (ctrl_sel),
        .ctrl_wen   (ctrl_wen),
        .ctrl_addr  (ctrl_addr),
        .ctrl_wdata (ctrl_wdata),
        .ctrl_wstrb (ctrl_wstrb),
        .ctrl_ready (ctrl_ready),
        .ctrl_rdata (ctrl_rdata),
        .ctrl_err   (ctrl_err),
        .tgt_sel    (tgt_sel),
        .tgt_wen    (tgt_wen),
        .tgt_addr   (tgt_addr),
        .tgt_wdata  (tgt_wdata),
        .tgt_wstrb  (tgt_wstrb),
        .tgt_rdata  (tgt_rdata),
        .tgt_ready  (tgt_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle at the falling edge where we sample and drive.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic request(input logic wen, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW/8-1:0] wstrb);
        ctrl_sel   = 1'b1;
        ctrl_wen   = wen;
        ctrl_addr  = addr;
        ctrl_wdata = wdata;
        ctrl_wstrb = wstrb;
    endtask

    initial begin
        tgt_rdata[0*DW +: DW] = 32'hFFFF0000;
        tgt_rdata[1*DW +: DW] = 32'h11111111;
        tgt_rdata[2*DW +: DW] = 32'h12345678;
        tgt_rdata[3*DW +: DW] = 32'h33333333;

        // Reset state
        @(negedge clock);
        @(negedge clock);
        check("rst_tgt_sel", 64'(tgt_sel), 64'h0);
        check("rst_ctrl_ready", 64'(ctrl_ready), 64'h0);
        check("rst_ctrl_rdata", 64'(ctrl_rdata), 64'h0);
        check("rst_ctrl_err", 64'(ctrl_err), 64'h0);
        check("rst_tgt_addr", 64'(tgt_addr), 64'h0);
        resetn = 1'b1;
        tick();

        // Read 0x064, target 2 ready with zero wait
        tgt_ready = 4'b0100;
        request(1'b0, 11'h064, '0, '0);
        tick(); // E0
        check("rd064_sel_e0", 64'(tgt_sel), 64'h4);
        check("rd064_addr", 64'(tgt_addr), 64'h064);
        check("rd064_wen", 64'(tgt_wen), 64'h0);
        check("rd064_ready_e0", 64'(ctrl_ready), 64'h0);
        tick(); // E0+1
        check("rd064_sel_e1", 64'(tgt_sel), 64'h0);
        check("rd064_ready_e1", 64'(ctrl_ready), 64'h0);
        tick(); // E0+2
        check("rd064_ready_e2", 64'(ctrl_ready), 64'h1);
        check("rd064_rdata", 64'(ctrl_rdata), 64'h12345678);
        check("rd064_err", 64'(ctrl_err), 64'h0);
        ctrl_sel = 1'b0;
        tick();
        check("rd064_ready_after", 64'(ctrl_ready), 64'h0);
        check("rd064_rdata_after", 64'(ctrl_rdata), 64'h0);
        check("rd064_no_restart", 64'(tgt_sel), 64'h0);

        // Write 0x000, target 0 delays ready
        tgt_ready = 4'b0000;
        request(1'b1, 11'h000, 32'hA5A5A5A5, 4'hF);
        tick(); // E0
        check("wr000_sel", 64'(tgt_sel), 64'h1);
        check("wr000_wen", 64'(tgt_wen), 64'h1);
        check("wr000_wdata", 64'(tgt_wdata), 64'hA5A5A5A5);
        check("wr000_wstrb", 64'(tgt_wstrb), 64'hF);
        ctrl_wdata = 32'h0; // registered copy must not follow the input
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wr000_sel_wait", 64'(tgt_sel), 64'h1);
            check("wr000_wdata_wait", 64'(tgt_wdata), 64'hA5A5A5A5);
            check("wr000_ready_wait", 64'(ctrl_ready), 64'h0);
        end
        tgt_ready = 4'b0001;
        tick(); // ready sampled
        check("wr000_sel_drop", 64'(tgt_sel), 64'h0);
        check("wr000_ready_ek", 64'(ctrl_ready), 64'h0);
        tgt_ready = 4'b0000;
        tick();
        check("wr000_ready", 64'(ctrl_ready), 64'h1);
        check("wr000_rdata", 64'(ctrl_rdata), 64'h0);
        check("wr000_err", 64'(ctrl_err), 64'h0);
        ctrl_sel = 1'b0;
        tick();
        check("wr000_ready_after", 64'(ctrl_ready), 64'h0);

        // Read 0x700 is unmapped
        tgt_ready = 4'b1111;
        request(1'b0, 11'h700, '0, '0);
        tick(); // E0
        check("rd700_sel", 64'(tgt_sel), 64'h0);
        check("rd700_ready_e0", 64'(ctrl_ready), 64'h0);
        tick(); // E0+1
        check("rd700_ready", 64'(ctrl_ready), 64'h1);
        check("rd700_err", 64'(ctrl_err), 64'h1);
        check("rd700_rdata", 64'(ctrl_rdata), 64'hDEADBEEF);
        ctrl_sel = 1'b0;
        tick();
        check("rd700_ready_after", 64'(ctrl_ready), 64'h0);
        check("rd700_err_after", 64'(ctrl_err), 64'h0);

        // Upper edge of window 3: 0x5FF hits
        request(1'b0, 11'h5FF, '0, '0);
        tick();
        check("rd5ff_sel", 64'(tgt_sel), 64'h8);
        tick();
        tick();
        check("rd5ff_ready", 64'(ctrl_ready), 64'h1);
        check("rd5ff_rdata", 64'(ctrl_rdata), 64'h33333333);
        check("rd5ff_err", 64'(ctrl_err), 64'h0);
        ctrl_sel = 1'b0;
        tick();

        // Write to 0x600 misses: error, zero data, no select
        request(1'b1, 11'h600, 32'hCAFEF00D, 4'hF);
        tick();
        check("wr600_sel", 64'(tgt_sel), 64'h0);
        tick();
        check("wr600_ready", 64'(ctrl_ready), 64'h1);
        check("wr600_err", 64'(ctrl_err), 64'h1);
        check("wr600_rdata", 64'(ctrl_rdata), 64'h0);
        ctrl_sel = 1'b0;
        tick();

        // Boundary between windows 0 and 1: 0x003 -> target 0, 0x004 -> target 1
        request(1'b0, 11'h003, '0, '0);
        tick();
        check("rd003_sel", 64'(tgt_sel), 64'h1);
        tick();
        tick();
        check("rd003_rdata", 64'(ctrl_rdata), 64'hFFFF0000);
        ctrl_sel = 1'b0;
        tick();

        // Reset during ACCESS
        tgt_ready = 4'b0000;
        request(1'b0, 11'h460, '0, '0);
        tick();
        check("rstacc_sel_before", 64'(tgt_sel), 64'h8);
        resetn = 1'b0;
        ctrl_sel = 1'b0;
        #1;
        check("rstacc_sel_async", 64'(tgt_sel), 64'h0);
        check("rstacc_addr_async", 64'(tgt_addr), 64'h0);
        tick();
        tick();
        resetn = 1'b1;
        tgt_ready = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rstacc_no_ready", 64'(ctrl_ready), 64'h0);
        end
        request(1'b0, 11'h004, '0, '0);
        tick();
        check("rstacc_next_sel", 64'(tgt_sel), 64'h2);
        tick();
        tick();
        check("rstacc_next_ready", 64'(ctrl_ready), 64'h1);
        check("rstacc_next_rdata", 64'(ctrl_rdata), 64'h11111111);
        check("rstacc_next_err", 64'(ctrl_err), 64'h0);
        ctrl_sel = 1'b0;
        tick();

        // Back-to-back reads with ctrl_sel held high
        request(1'b0, 11'h004, '0, '0);
        tick(); // E0
        check("b2b_sel_a", 64'(tgt_sel), 64'h2);
        tick(); // E0+1
        tick(); // E0+2
        check("b2b_ready_a", 64'(ctrl_ready), 64'h1);
        check("b2b_rdata_a", 64'(ctrl_rdata), 64'h11111111);
        ctrl_addr = 11'h060;
        tick(); // E0+3: second request sampled
        check("b2b_sel_b", 64'(tgt_sel), 64'h4);
        check("b2b_gap_e3", 64'(ctrl_ready), 64'h0);
        tick(); // E0+4
        check("b2b_gap_e4", 64'(ctrl_ready), 64'h0);
        tick(); // E0+5
        check("b2b_ready_b", 64'(ctrl_ready), 64'h1);
        check("b2b_rdata_b", 64'(ctrl_rdata), 64'h12345678);
        ctrl_sel = 1'b0;
        tick();
        check("b2b_ready_after", 64'(ctrl_ready), 64'h0);

`ifdef CAXI4DMA_CTRL_IF_TIMEOUT_EN
        // Target 3 never ready: select held exactly TIMEOUT_CYC cycles
        tgt_ready = 4'b0000;
        request(1'b0, 11'h460, '0, '0);
        tick(); // E0
        n_high = 0;
        for (int i = 0; i < 20; i++) begin
            if (tgt_sel[3]) begin
                n_high++;
                tick();
            end
        end
        check("tmo_sel_cycles", 64'(n_high), 64'd8);
        check("tmo_ready_e8", 64'(ctrl_ready), 64'h0);
        tick();
        check("tmo_ready", 64'(ctrl_ready), 64'h1);
        check("tmo_err", 64'(ctrl_err), 64'h1);
        check("tmo_rdata", 64'(ctrl_rdata), 64'hDEADBEEF);
        ctrl_sel = 1'b0;
        tick();

        // Ready in the expiry cycle wins
        request(1'b0, 11'h460, '0, '0);
        tick(); // E0
        for (int i = 0; i < 7; i++) tick();
        check("tmo_race_sel", 64'(tgt_sel), 64'h8);
        tgt_ready = 4'b1000;
        tick(); // E0+8
        check("tmo_race_sel_drop", 64'(tgt_sel), 64'h0);
        tgt_ready = 4'b0000;
        tick();
        check("tmo_race_ready", 64'(ctrl_ready), 64'h1);
        check("tmo_race_err", 64'(ctrl_err), 64'h0);
        check("tmo_race_rdata", 64'(ctrl_rdata), 64'h33333333);
        ctrl_sel = 1'b0;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
